maxpool_window_unit: RTL and testbench
======================================

// Module: maxpool_window_unit
// PURPOSE
//  - Streaming max-pool stage: takes N-bit signed activations one per handshake and emits the maximum of each
//    group of POOL_SIZE consecutive samples (e.g. 4 = one 2x2 window), one result per window.
//  - Sits between the conv/PE output stream and the pooled-feature writeback; owns compare, running-max register,
//    window counter and output holding register.
// PARAMETERS
//  - N          8   sample/result width, two's complement
//  - POOL_SIZE  4   samples per window, >=2; counter width = $clog2(POOL_SIZE)
// PORTS
//  - clk           in   1  rising-edge clock
//  - master_rst_n  in   1  asynchronous active-low reset
//  - clr           in   1  synchronous flush: abort partial window, drop pending result
//  - in_valid      in   1  in_data valid
//  - in_ready      out  1  unit accepts in_data this cycle
//  - in_data       in   N  signed activation
//  - out_valid     out  1  out_data holds a completed window max
//  - out_ready     in   1  consumer takes out_data this cycle
//  - out_data      out  N  signed window maximum
//  - busy          out  1  partial window in progress or result pending
// BEHAVIOUR
//  - Reset (async, master_rst_n=0): state=ACCUM, cnt=0, run_max=0, out_data=0, out_valid=0, busy=0.
//  - Accept = in_valid & in_ready; emit = out_valid & out_ready.
//  - States: ACCUM (collecting), HOLD (result registered, waiting on consumer).
//  - ACCUM: in_ready=1. On accept with cnt==0: run_max<=in_data (window reset, no compare).
//    cnt 1..POOL_SIZE-2: run_max<=max(run_max,in_data), signed. cnt==POOL_SIZE-1: out_data<=max(run_max,in_data),
//    out_valid<=1, cnt<=0, ->HOLD. Latency: out_valid high cycle after last sample accepted.
//  - HOLD: in_ready=out_ready (first sample of next window accepted same cycle the result drains).
//    On emit: out_valid<=0, ->ACCUM; a simultaneous accept loads run_max, cnt<=1.
//    No emit: in_ready=0, out_data/out_valid stable (no drop, no overwrite).
//  - Ties: equal values keep run_max (result identical either way).
//  - Compare is N-bit signed; no widening; -2^(N-1) is a legal minimum.
//  - clr (sync, priority over all handshakes): cnt<=0, out_valid<=0, state<=ACCUM, run_max<=0; in_ready=0 and
//    no accept that cycle. out_data keeps its value.
//  - Reset mid-window or while HOLD: all state discarded immediately, no output produced.
//  - busy = (cnt!=0) | out_valid.
// CONFIGURATION
//  - MAXPOOL_RELU_EN defined: out_data <= (max<0) ? 0 : max, i.e. fused ReLU on the registered result;
//    run_max stays unclamped. Undefined: out_data is raw signed max; negatives pass through.
// STRUCTURE
//  - Package maxpool_pkg: state enum {ACCUM,HOLD}, MAXPOOL_DATA_W default, cnt-width function.
//  - Sub-module max_cmp2 (combinational, param N): signed a,b -> max; shared by mid-window and final update.
//  - Remaining control/registers in this module.
// TESTING
//  - Window 3,-5,7,2 (N=8,POOL=4), continuous valid, out_ready=1 -> out_data=7, out_valid 1 cycle after 4th accept.
//  - All-negative -8,-3,-128,-9 -> out=-3; with MAXPOOL_RELU_EN -> out=0.
//  - out_ready=0 for 5 cycles after result -> in_ready=0, out_data stable; release with next window's first
//    sample valid -> emit and accept same cycle, next window completes after 3 more accepts.
//  - clr asserted after 2 samples of window -> busy=0 next cycle; following 4 samples 1,1,1,9 -> out=9 only.
//  - master_rst_n pulsed low mid-window and during HOLD -> all outputs 0 asynchronously, no stale result after
//    release.
//  - Random valid/ready bubbles, 1000 windows vs reference model -> result order/values match, no loss/duplicate.

Source files
------------

// File: rtl/maxpool_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_pkg
// Shared types and constants for the streaming max-pool stage.
//   - state_t         : window FSM state (ACCUM collecting, HOLD result pending)
//   - MAXPOOL_DATA_W  : default sample/result width
//   - cnt_width()     : window counter width for a given pool size
// -----------------------------------------------------------------------------
package maxpool_pkg;

    localparam int MAXPOOL_DATA_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // A pool size of 1 would give $clog2 == 0; keep at least one bit so the
    // counter declaration stays legal for any parameterisation.
    function automatic int cnt_width(input int pool_size);
        return (pool_size > 1) ? $clog2(pool_size) : 1;
    endfunction

endpackage

// File: rtl/max_cmp2.sv
// -----------------------------------------------------------------------------
// max_cmp2
// Combinational two's-complement maximum of two N-bit values.
// Ports:
//   a_i   in  N  signed operand (running max)
//   b_i   in  N  signed operand (new sample)
//   max_o out N  max(a_i, b_i); on a tie a_i is returned
// -----------------------------------------------------------------------------
module max_cmp2 #(
    parameter int N = 8
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N-1:0] max_o
);

    // Strict greater-than keeps a_i on ties.
    assign max_o = (b_i > a_i) ? b_i : a_i;

endmodule

// File: rtl/maxpool_window_unit.sv
// -----------------------------------------------------------------------------
// maxpool_window_unit
// Streaming max-pool stage: accepts one signed sample per handshake and emits
// the maximum of every POOL_SIZE consecutive samples, one result per window.
//
// Optional feature macro: MAXPOOL_RELU_EN
//   defined   -> the registered result is clamped at zero (fused ReLU);
//                the running max itself is never clamped.
//   undefined -> raw signed maximum, negatives pass through.
//
// Ports:
//   clk           in   1  rising-edge clock
//   master_rst_n  in   1  asynchronous active-low reset
//   clr           in   1  synchronous flush (drops partial window and result)
//   in_valid      in   1  in_data valid
//   in_ready      out  1  sample accepted this cycle when in_valid is high
//   in_data       in   N  signed activation
//   out_valid     out  1  out_data holds a completed window maximum
//   out_ready     in   1  consumer takes out_data this cycle
//   out_data      out  N  signed window maximum
//   busy          out  1  partial window in progress or result pending
//   state_dbg     out  -  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and a producer holding valid keeps its
// data stable until the transfer.
// -----------------------------------------------------------------------------
module maxpool_window_unit
    import maxpool_pkg::*;
#(
    parameter int N         = MAXPOOL_DATA_W,
    parameter int POOL_SIZE = 4
) (
    input  logic         clk,
    input  logic         master_rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy,
    output state_t       state_dbg
);

    localparam int CNT_W = cnt_width(POOL_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     run_max_q, run_max_d;
    logic [N-1:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             emit;
    logic [N-1:0]     max_v;
    logic [N-1:0]     result_v;

    max_cmp2 #(.N(N)) u_cmp (
        .a_i   (run_max_q),
        .b_i   (in_data),
        .max_o (max_v)
    );

`ifdef MAXPOOL_RELU_EN
    assign result_v = max_v[N-1] ? '0 : max_v;
`else
    assign result_v = max_v;
`endif

    // In HOLD the next window's first sample may only enter in the same cycle
    // the pending result drains. clr blocks every handshake.
    assign in_ready = !clr && ((state_q == ACCUM) || out_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid_q && out_ready && !clr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (clr) begin
            state_d     = ACCUM;
            cnt_d       = '0;
            run_max_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            if (emit) begin
                out_valid_d = 1'b0;
                state_d     = ACCUM;
            end
            if (accept) begin
                if (cnt_q == '0) begin
                    // First sample of a window seeds the running max.
                    run_max_d = in_data;
                    cnt_d     = CNT_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    out_data_d  = result_v;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = HOLD;
                end else begin
                    run_max_d = max_v;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            run_max_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_max_q   <= run_max_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0) || out_valid_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_maxpool_window_unit.sv
`timescale 1ns/1ps
module tb_maxpool_window_unit;
  import maxpool_pkg::*;

  localparam int W = 8;
  localparam int POOL = 4;
  localparam int RAND_WINDOWS = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic master_rst_n;
  always #5 clk = ~clk;

  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  state_t       state_dbg;

  maxpool_window_unit #(.N(W), .POOL_SIZE(POOL)) dut (
    .clk          (clk),
    .master_rst_n (master_rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] relu_exp(input logic [W-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one sample and returns at posedge+1 after it was accepted.
  task automatic send(input logic [W-1:0] d);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_one;
    @(posedge clk); #1;
    check("drained_valid", out_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent, emitted, mcnt;
    logic [W-1:0] mmax;
    logic acc, em;

    master_rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, ACCUM);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); master_rst_n = 1'b1;
    @(posedge clk); #1;

    // Window 3,-5,7,2 -> 7
    send(8'd3); send(8'hFB); send(8'd7);
    check("w1_not_yet", out_valid, 1'b0);
    check("w1_busy_mid", busy, 1'b1);
    send(8'd2);
    check("w1_valid", out_valid, 1'b1);
    check("w1_data", out_data, 8'd7);
    check("w1_state", state_dbg, HOLD);
    drain_one();

    // All negative -8,-3,-128,-9 -> -3 (or 0 with ReLU)
    send(8'hF8); send(8'hFD); send(8'h80); send(8'hF7);
    check("w2_valid", out_valid, 1'b1);
    check("w2_data", out_data, relu_exp(8'hFD));
    drain_one();

    // Back-pressure: result held 5 cycles, then drain + accept together
    out_ready = 1'b0;
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    in_valid = 1'b1; in_data = 8'd5;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, 8'd40);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_busy", busy, 1'b1);
    send(8'd6); send(8'd7);
    check("w3_not_yet", out_valid, 1'b0);
    send(8'd1);
    check("w3_valid", out_valid, 1'b1);
    check("w3_data", out_data, 8'd7);
    drain_one();

    // clr after two samples
    send(8'd50); send(8'd60);
    check("pre_clr_busy", busy, 1'b1);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd100;
    #1;
    check("clr_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_valid", out_valid, 1'b0);
    check("clr_keeps_data", out_data, 8'd7);
    send(8'd1); send(8'd1); send(8'd1);
    check("w4_not_yet", out_valid, 1'b0);
    send(8'd9);
    check("w4_valid", out_valid, 1'b1);
    check("w4_data", out_data, 8'd9);
    drain_one();

    // Async reset mid-window
    send(8'd4); send(8'd5);
    #2 master_rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_valid", out_valid, 1'b0);
    check("rstmid_data", out_data, 8'h00);
    @(negedge clk); master_rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_after_busy", busy, 1'b0);

    // Async reset during HOLD
    out_ready = 1'b0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    check("rsthold_pre_valid", out_valid, 1'b1);
    #2 master_rst_n = 1'b0;
    #1;
    check("rsthold_valid", out_valid, 1'b0);
    check("rsthold_data", out_data, 8'h00);
    check("rsthold_state", state_dbg, ACCUM);
    @(negedge clk); master_rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rsthold_no_stale", out_valid, 1'b0);
    send(8'd11); send(8'd12); send(8'd13); send(8'd14);
    check("w5_data", out_data, 8'd14);
    check("w5_valid", out_valid, 1'b1);
    drain_one();

    // Random bubbles vs reference model
    sent = 0; emitted = 0; mcnt = 0; mmax = '0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 60000 && emitted < RAND_WINDOWS; cyc++) begin
      if (!in_valid && sent < RAND_WINDOWS * POOL && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = W'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      em  = out_valid && out_ready;
      if (em) begin
        if (exp_q.size() == 0) check("rand_spurious", 32'd1, 32'd0);
        else check("rand_out", out_data, exp_q.pop_front());
        emitted++;
      end
      if (acc) begin
        if (mcnt == 0 || $signed(in_data) > $signed(mmax)) mmax = in_data;
        mcnt++;
        if (mcnt == POOL) begin
          exp_q.push_back(relu_exp(mmax));
          mcnt = 0;
        end
        sent++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("rand_sent", sent, RAND_WINDOWS * POOL);
    check("rand_emitted", emitted, RAND_WINDOWS);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
